// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with one-shot/auto-reload modes and masked level IRQ
module timer_dev #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [15:0] prescaler;
  logic        irq_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ctrl      <= 4'd0;
      preset    <= 32'd0;
      count     <= 32'd0;
      prescaler <= 16'd0;
      irq_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl[0]) state <= S_LOAD;
        end
        S_LOAD: begin
          count     <= preset;
          prescaler <= 16'd0;
          state     <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl[0]) begin
            state <= S_IDLE;
          end else if (prescaler == PS_LAST) begin
            prescaler <= 16'd0;
            // COUNT of 0 or 1 both terminate, so PRESET=0 acts like PRESET=1
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= 32'd0;
              irq_flag <= 1'b1;
              state    <= S_INT;
            end
          end else begin
            prescaler <= prescaler + 16'd1;
          end
        end
        S_INT: begin
          if (ctrl[2:1] == 2'b01) irq_flag <= 1'b0;
          else                    ctrl[0]  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // CPU writes come last so they win over same-edge FSM updates
      if (WE) begin
        case (Addr)
          2'd0: begin
            ctrl     <= Din[3:0];
            irq_flag <= 1'b0;
          end
          2'd1: begin
            preset   <= Din;
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      2'd0:    Dout = {28'd0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev with PRESCALE=1 and PRESCALE=4 instances
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  Addr = 2'd0;
  logic        WE = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] dout0, dout1;
  logic        irq0, irq1;

  int n_pass = 0;
  int n_total = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  timer_dev #(.PRESCALE(1)) dut0 (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(dout0), .IRQ(irq0)
  );
  timer_dev #(.PRESCALE(4)) dut1 (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(dout1), .IRQ(irq1)
  );

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_DONE = 3;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    int          ticks;
    int          ph;
    logic        flag;
  } mst_t;

  mst_t m0 = '0;
  mst_t m1 = '0;

  function automatic mst_t mnext(mst_t s, int ps, logic rst, logic we,
                                 logic [1:0] a, logic [31:0] d);
    mst_t n;
    n = s;
    if (rst) return '0;
    if (s.ph == PH_IDLE) begin
      if (s.ctrl[0]) n.ph = PH_LOAD;
    end else if (s.ph == PH_LOAD) begin
      n.count = s.preset;
      n.ticks = 0;
      n.ph = PH_RUN;
    end else if (s.ph == PH_RUN) begin
      if (!s.ctrl[0]) n.ph = PH_IDLE;
      else if (s.ticks + 1 < ps) n.ticks = s.ticks + 1;
      else begin
        n.ticks = 0;
        if (s.count >= 2) n.count = s.count - 1;
        else begin
          n.count = 0;
          n.flag = 1'b1;
          n.ph = PH_DONE;
        end
      end
    end else begin
      if (s.ctrl[2:1] == 2'b01) n.flag = 1'b0;
      else n.ctrl[0] = 1'b0;
      n.ph = PH_IDLE;
    end
    if (we && a == 2'd0) begin
      n.ctrl = d[3:0];
      n.flag = 1'b0;
    end
    if (we && a == 2'd1) begin
      n.preset = d;
      n.flag = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [31:0] mread(mst_t s, logic [1:0] a);
    if (a == 2'd0) return {28'd0, s.ctrl};
    if (a == 2'd1) return s.preset;
    if (a == 2'd2) return s.count;
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    m0 <= mnext(m0, 1, reset, WE, Addr, Din);
    m1 <= mnext(m1, 4, reset, WE, Addr, Din);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_dout_ps1", dout0, mread(m0, Addr));
      check("model_irq_ps1", {31'd0, irq0}, {31'd0, m0.flag & m0.ctrl[3]});
      check("model_dout_ps4", dout1, mread(m1, Addr));
      check("model_irq_ps4", {31'd0, irq1}, {31'd0, m1.flag & m1.ctrl[3]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din = d;
    WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    Addr = a;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    WE = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pulses, first, last, wide;
    logic prev;

    do_reset();
    cmp_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0]);
      check($sformatf("reset_dout_a%0d", a), dout0, 32'd0);
    end
    check("reset_irq", {31'd0, irq0}, 32'd0);

    // one-shot timeline with PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    tick(); rd(2'd2); check("os_e2_count", dout0, 32'd3);
    tick(); check("os_e3_count", dout0, 32'd2);
    tick(); check("os_e4_count", dout0, 32'd1);
    check("os_e4_irq", {31'd0, irq0}, 32'd0);
    tick(); check("os_e5_count", dout0, 32'd0);
    check("os_e5_irq", {31'd0, irq0}, 32'd1);
    tick(); rd(2'd0); check("os_e6_ctrl", dout0, 32'h8);
    check("os_e6_irq", {31'd0, irq0}, 32'd1);
    wr(2'd0, 32'h8);
    check("os_clear_irq", {31'd0, irq0}, 32'd0);

    // auto-reload, PRESET=2: period 5
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    pulses = 0; first = -1; last = -1; wide = 0; prev = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (irq0) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
        if (prev) wide++;
      end
      prev = irq0;
    end
    check("ar_pulses", pulses, 32'd4);
    check("ar_first", first, 32'd4);
    check("ar_span", last - first, 32'd15);
    check("ar_wide", wide, 32'd0);

    // PRESCALE=4 instance, PRESET=2 one-shot
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(); tick();
    rd(2'd2);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) check("ps4_count_hold", dout1, 32'd2);
      if (i == 4) check("ps4_count_dec", dout1, 32'd1);
      if (i < 8) check($sformatf("ps4_irq_low_%0d", i), {31'd0, irq1}, 32'd0);
    end
    check("ps4_irq_at8", {31'd0, irq1}, 32'd1);

    // IM=0: flag set but masked, then cleared by CTRL write
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    rd(2'd2); check("im0_count", dout0, 32'd0);
    check("im0_irq", {31'd0, irq0}, 32'd0);
    wr(2'd0, 32'h8);
    rd(2'd0); check("im0_ctrl", dout0, 32'h8);
    check("im0_after_unmask", {31'd0, irq0}, 32'd0);

    // disable mid-count freezes COUNT
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    wr(2'd0, 32'h0);
    tick(); tick(); tick();
    rd(2'd2); check("freeze_count", dout0, 32'd7);

    // re-enable reloads; PRESET write and Addr 2 write mid-count
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    tick(); tick();
    rd(2'd2); check("reload_count", dout0, 32'd5);
    tick();
    wr(2'd1, 32'd20);
    rd(2'd2); check("preset_midrun", dout0, 32'd3);
    wr(2'd2, 32'hFFFF);
    rd(2'd2); check("we_addr2_ignored", dout0, 32'd2);

    do_reset();
    for (int a = 0; a < 3; a++) begin
      rd(a[1:0]);
      check($sformatf("midreset_a%0d", a), dout0, 32'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Addr = 2'($urandom_range(0, 3));
      WE = ($urandom_range(0, 7) == 0);
      if (Addr == 2'd1) Din = $urandom_range(0, 5);
      else Din = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      tick();
      WE = 1'b0;
      reset = 1'b0;
      Addr = 2'($urandom_range(0, 3));
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer on the data-memory device bus, hit range 0x00007F00–0x00007F0B.
- It is the responder for CPU load/store accesses issued from the MEM stage.
- The bridge decodes the range and forwards word-aligned accesses with Addr = A[3:2].
- Sub-word accesses and writes to COUNT are excepted upstream and never reach this block.
- It raises IRQ to the CP0 interrupt input.

Parameters:
- PRESCALE, 1: clock cycles per COUNT decrement in CNT state; legal range 1..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Addr  input  2  register word select (A[3:2]); 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- WE  input  1  word write strobe, already qualified by address hit
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr
- IRQ  output  1  interrupt request, level

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, prescaler=0, irq_flag=0. Hence Dout reads as 0 for Addr 0, 1 and 2, and IRQ=0.
- CTRL register: [0]=Enable, [2:1]=Mode, [3]=IM (interrupt mask).
  - Bits [31:4] read 0; writes to them are ignored.
  - Mode 00 = one-shot; Mode 01 = auto-reload; Modes 1x behave as 00.
- Reads: 0-cycle latency.
  - Addr 0: {28'b0, CTRL[3:0]}. Addr 1: PRESET. Addr 2: COUNT. Addr 3: 0.
- Writes: take effect at the clock edge.
  - WE with Addr 2 or Addr 3 is ignored.
  - A write to CTRL or PRESET clears irq_flag.
- State transitions evaluate the register values held before the edge.
  - IDLE: Enable=1 -> LOAD.
  - LOAD: COUNT<=PRESET, prescaler<=0 -> CNT.
  - CNT with Enable=0: -> IDLE; COUNT holds.
  - CNT with Enable=1, on a prescaler tick (prescaler==PRESCALE-1, prescaler then wraps to 0):
    - COUNT>1: COUNT<=COUNT-1, stay in CNT.
    - COUNT<=1: COUNT<=0, irq_flag<=1, -> INT.
  - CNT with Enable=1, not a tick: prescaler<=prescaler+1.
  - INT, Mode 0: CTRL[0]<=0 -> IDLE; irq_flag holds until cleared by a CTRL or PRESET write.
  - INT, Mode 1: irq_flag<=0 -> IDLE. Enable is still 1, so the timer reloads.
    - IRQ is a one-cycle pulse per period.
    - Period is PRESET*PRESCALE+3 cycles for PRESET>=1.
- PRESET=0 behaves as PRESET=1.
- IRQ = irq_flag & CTRL[3] (combinational). Changing IM does not alter irq_flag.
- Simultaneous events:
  - A CPU CTRL write in the same cycle as the INT Mode-0 Enable clear: the CPU value wins. Its write side effect still clears irq_flag.
  - A PRESET write during CNT does not affect the running COUNT; it applies at the next LOAD.
  - A CTRL write setting Enable=0 during CNT: next state IDLE, COUNT frozen and readable.
- Reset mid-count: all state returns to the reset values at the next edge. Any pending IRQ drops after that edge.
- COUNT never underflows past 0; no wrap-around.

Test Plan:
- Reset, then read Addr 0/1/2/3 -> Dout=0 for each; IRQ=0.
- PRESET=3, then CTRL=0x9 (Mode 0, IM=1, Enable), written at edge E0 -> timeline:
  - E1: LOAD.
  - E2: COUNT=3.
  - E3: COUNT=2.
  - E4: COUNT=1.
  - E5: COUNT=0, IRQ=1.
  - E6: CTRL reads 0x8; IRQ stays 1.
  - A write of CTRL=0x8 then drops IRQ at the next edge.
- PRESET=2, CTRL=0xB (Mode 1) -> IRQ is a 1-cycle pulse every 5 cycles for at least 3 periods; COUNT sequence is 2,1,0,…,2,1,0.
- PRESCALE=4, PRESET=2, Mode 0 -> COUNT holds each value for 4 cycles; IRQ at 8 cycles after entering CNT.
- CTRL=0x1 with IM=0 -> COUNT reaches 0 and IRQ stays 0. A following write CTRL=0x8 leaves IRQ=0 because the write clears irq_flag.
- Mid-count checks:
  - Mid-count CTRL=0 -> COUNT frozen and state IDLE; re-enable reloads from PRESET.
  - Mid-count PRESET write -> the current run is unchanged.
  - Mid-count reset -> all registers 0 next cycle.
  - WE to Addr 2 -> COUNT unaffected.
